// File: rtl/fpd_mantissa_divider.sv
// rtl/fpd_mantissa_divider.sv - radix-2 restoring significand divider for the FP divide datapath
//
// Purpose: computes floor(dividend * 2^(MANTISSA_WIDTH+2) / divisor) over
// MANTISSA_WIDTH+3 iterations, plus a sticky flag for a non-zero remainder.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i                 begin a division (sampled only while idle)
//   dividend_i, divisor_i   normalized significands, hidden bit included
//   busy_o                  division in progress
//   done_o                  one-cycle pulse, quotient_o/sticky_o valid
//   quotient_o              quotient with guard/round bits below the LSB
//   sticky_o                final remainder non-zero
module fpd_mantissa_divider #(
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [MANTISSA_WIDTH:0]   dividend_i,
  input  logic [MANTISSA_WIDTH:0]   divisor_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [MANTISSA_WIDTH+2:0] quotient_o,
  output logic                      sticky_o
);

  localparam int N  = MANTISSA_WIDTH + 3;
  localparam int RW = MANTISSA_WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nx;
  logic [RW-1:0]         rem_q, rem_nx;
  logic [MANTISSA_WIDTH:0] div_q, div_nx;
  logic [N-1:0]          q_q, q_nx;
  logic [CW-1:0]         cnt_q, cnt_nx;
  logic                  done_nx;
  logic [N-1:0]          quot_nx;
  logic                  sticky_nx;

  logic [RW-1:0]         div_ext;
  logic [RW-1:0]         diff;
  logic                  ge;

  // Compare and subtract in the remainder's width; the divisor is zero-extended.
  assign div_ext = {1'b0, div_q};
  assign ge      = (rem_q >= div_ext);
  assign diff    = rem_q - div_ext;

  always_comb begin
    state_nx  = state;
    rem_nx    = rem_q;
    div_nx    = div_q;
    q_nx      = q_q;
    cnt_nx    = cnt_q;
    done_nx   = 1'b0;
    quot_nx   = quotient_o;
    sticky_nx = sticky_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          rem_nx   = {1'b0, dividend_i};
          div_nx   = divisor_i;
          q_nx     = '0;
          cnt_nx   = CW'(N);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        q_nx   = {q_q[N-2:0], ge};
        // The MSB dropped by the shift is always zero for normalized operands.
        rem_nx = ge ? {diff[RW-2:0], 1'b0} : {rem_q[RW-2:0], 1'b0};
        cnt_nx = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_nx  = IDLE;
          done_nx   = 1'b1;
          quot_nx   = q_nx;
          sticky_nx = (rem_nx != '0);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem_q      <= '0;
      div_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      done_o     <= 1'b0;
      quotient_o <= '0;
      sticky_o   <= 1'b0;
    end else begin
      state      <= state_nx;
      rem_q      <= rem_nx;
      div_q      <= div_nx;
      q_q        <= q_nx;
      cnt_q      <= cnt_nx;
      done_o     <= done_nx;
      quotient_o <= quot_nx;
      sticky_o   <= sticky_nx;
    end
  end

  // state is a flop, so busy_o is a registered output.
  assign busy_o = (state == BUSY);

endmodule

// File: tb/tb_fpd_mantissa_divider.sv
// tb/tb_fpd_mantissa_divider.sv - scoreboard bench for fpd_mantissa_divider
module tb_fpd_mantissa_divider;

  localparam int MW = 23;
  localparam int N  = MW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [MW:0]   dividend_i = '0;
  logic [MW:0]   divisor_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [MW+2:0] quotient_o;
  logic          sticky_o;

  fpd_mantissa_divider #(.MANTISSA_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o),
    .quotient_o(quotient_o), .sticky_o(sticky_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MW+2:0] q;
    logic          s;
  } exp_t;

  exp_t exp_q[$];
  logic [MW+2:0] last_q = '0;
  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [MW:0] a, input logic [MW:0] b);
    exp_t e;
    longint unsigned num, den;
    num = longint'(a) << (MW + 2);
    den = longint'(b);
    e.q = (MW+3)'(num / den);
    e.s = (num % den) != 0;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (done_o) begin
      if (prev_done) chk("done_single_pulse", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", quotient_o, e.q);
        chk("sticky", sticky_o, e.s);
        last_q = e.q;
      end
    end
    prev_done = done_o;
  end

  task automatic drive(input logic [MW:0] a, input logic [MW:0] b, input bit push);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    if (push) exp_q.push_back(model(a, b));
  endtask

  // Wait for done; optional ignored start pulses at cycles p1/p2 and a hold check.
  task automatic wait_done(input int p1, input int p2, input bit hold_chk,
                           output int cyc, output int busy_cnt);
    bit ok;
    ok = 0;
    cyc = 0;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1;
        break;
      end
      cyc++;
      if (busy_o) busy_cnt++;
      if (hold_chk && cyc == 5) chk("quotient_hold", quotient_o, last_q);
      if (cyc == p1 || cyc == p2) drive(24'h812345, 24'hF00001, 0);
      else start_i = 1'b0;
    end
    start_i = 1'b0;
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [MW:0] a, input logic [MW:0] b);
    int cyc, bc;
    @(negedge clk);
    drive(a, b, 1);
    wait_done(0, 0, 0, cyc, bc);
    chk("latency", cyc, N);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc, dn;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_quotient", quotient_o, 0);
    chk("reset_sticky", sticky_o, 0);
    rst_n = 1'b1;

    // Directed cases
    run(24'h800000, 24'h800000);
    run(24'hC00000, 24'h800000);
    run(24'h800000, 24'hC00000);
    run(24'hFFFFFF, 24'h800000);
    run(24'h800000, 24'hFFFFFF);

    // Starts during a running division are ignored; outputs hold meanwhile
    @(negedge clk);
    drive(24'hA00000, 24'hE00000, 1);
    wait_done(5, 25, 1, cyc, bc);
    chk("hs_latency", cyc, N);
    chk("hs_busy_cycles", bc, N);

    // Start in the done cycle: back-to-back division
    drive(24'hFFFFFF, 24'hFFFFFF, 1);
    wait_done(0, 0, 0, cyc, bc);
    chk("b2b_latency", cyc, N);

    // Asynchronous reset mid-division
    @(negedge clk);
    drive(24'h900000, 24'hB00000, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_quotient", quotient_o, 0);
    chk("abort_sticky", sticky_o, 0);
    exp_q.delete();
    last_q = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    chk("abort_no_done", dn, 0);
    run(24'h800000, 24'h800000);

    // Randomized normalized operands, with random idle gaps
    for (int i = 0; i < 1500; i++) begin
      logic [MW:0] a, b;
      a = {1'b1, MW'($urandom)};
      b = {1'b1, MW'($urandom)};
      if (i % 7 == 0) b = {1'b1, {MW{1'b1}}};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
